// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch-redirect bubbles and
// post-reset flush sequencing for the 5-stage RV32 pipeline.
module hazard_ctrl #(
  parameter int INIT_CYCLES = 4,
  parameter int BR_EXTRA    = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_write_reg,
  input  logic             ex_branch_taken,
  input  logic             clr_cnt,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_BFL  = 2'd2;

  localparam logic [2:0] CNT_INIT = 3'(INIT_CYCLES - 1);
  localparam logic [2:0] CNT_BR   = 3'(BR_EXTRA - 1);
  localparam bit         HAS_BFL  = (BR_EXTRA > 0);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  logic rs1_hit;
  logic rs2_hit;
  logic lu;
  logic in_init;
  logic in_run;
  logic in_bfl;
  logic br;
  logic stall;
  logic run_ok;
  logic flush_inc;

  // Hazard detection and cycle classification
  always_comb begin
    rs1_hit   = id_uses_rs1 && (id_rs1 == ex_write_reg);
    rs2_hit   = id_uses_rs2 && (id_rs2 == ex_write_reg);
    lu        = ex_memRead && (ex_write_reg != 5'd0)
                && (rs1_hit || rs2_hit);
    in_init   = (state_q == S_INIT);
    in_run    = (state_q == S_RUN);
    in_bfl    = (state_q == S_BFL);
    br        = in_run && ex_branch_taken;
    stall     = in_run && !ex_branch_taken && lu;
    run_ok    = in_run && !ex_branch_taken && !lu;
    flush_inc = br || in_bfl;
  end

  // State and shared down-counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= CNT_INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_INIT: begin
        if (cnt_q == 3'd0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RUN: begin
        if (ex_branch_taken && HAS_BFL) begin
          state_d = S_BFL;
          cnt_d   = CNT_BR;
        end
      end
      S_BFL: begin
        if (cnt_q == 3'd0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = CNT_INIT;
      end
    endcase
  end

  // Mealy control outputs; an illegal state looks like INIT
  always_comb begin
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b1;
    id_ex_flush = 1'b1;
    unique case (1'b1)
      in_init: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      flush_inc: begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      stall: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b1;
      end
      run_ok: begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
      end
      default: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
    endcase
  end

  // Saturating load-use stall counter; clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Saturating branch flush counter; clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (clr_cnt) begin
      flush_cnt <= '0;
    end else if (flush_inc && (flush_cnt != '1)) begin
      flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl
// (INIT_CYCLES=4, BR_EXTRA=1, CNT_W=4).
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       ex_memRead;
  logic [4:0] ex_write_reg;
  logic       ex_branch_taken;
  logic       clr_cnt;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic [3:0] stall_cnt;
  logic [3:0] flush_cnt;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(
    .INIT_CYCLES(4),
    .BR_EXTRA(1),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2),
    .ex_memRead(ex_memRead),
    .ex_write_reg(ex_write_reg),
    .ex_branch_taken(ex_branch_taken),
    .clr_cnt(clr_cnt),
    .pc_write(pc_write),
    .if_id_write(if_id_write),
    .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // {pc_write, if_id_write, if_id_flush, id_ex_flush}
  task automatic chk_ctl(input string tag,
                         input logic [3:0] exp);
    chk(tag, {28'd0, pc_write, if_id_write,
              if_id_flush, id_ex_flush}, {28'd0, exp});
  endtask

  task automatic set_lu(input logic mr,
                        input logic [4:0] wr,
                        input logic [4:0] r1,
                        input logic u1,
                        input logic [4:0] r2,
                        input logic u2);
    ex_memRead   = mr;
    ex_write_reg = wr;
    id_rs1       = r1;
    id_uses_rs1  = u1;
    id_rs2       = r2;
    id_uses_rs2  = u2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_cnt = 1'b0;
    ex_branch_taken = 1'b0;
    set_lu(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);

    // reset state
    #12;
    chk("rst_state", {30'd0, state}, 32'd0);
    chk_ctl("rst_ctl", 4'b0011);
    chk("rst_stall", {28'd0, stall_cnt}, 32'd0);
    chk("rst_flush", {28'd0, flush_cnt}, 32'd0);

    // INIT ignores a branch request
    rst_n = 1'b1;
    ex_branch_taken = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("init_st%0d", i), {30'd0, state}, 32'd0);
      chk_ctl($sformatf("init_ctl%0d", i), 4'b0011);
    end
    ex_branch_taken = 1'b0;
    tick();
    chk("run_state", {30'd0, state}, 32'd1);
    chk_ctl("run_ctl", 4'b1100);
    chk("init_flushcnt", {28'd0, flush_cnt}, 32'd0);

    // load-use on rs2
    set_lu(1'b1, 5'd5, 5'd1, 1'b1, 5'd5, 1'b1);
    #1;
    chk_ctl("lu_rs2_ctl", 4'b0001);
    tick();
    chk("lu_rs2_cnt", {28'd0, stall_cnt}, 32'd1);
    set_lu(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    chk_ctl("lu_clear_ctl", 4'b1100);

    // x0 destination: no stall
    set_lu(1'b1, 5'd0, 5'd1, 1'b1, 5'd0, 1'b1);
    #1;
    chk_ctl("lu_x0_ctl", 4'b1100);
    tick();

    // rs2 matches but unused: no stall
    set_lu(1'b1, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0);
    #1;
    chk_ctl("lu_unused_ctl", 4'b1100);
    tick();
    chk("lu_nostall_cnt", {28'd0, stall_cnt}, 32'd1);

    // load-use on rs1
    set_lu(1'b1, 5'd7, 5'd7, 1'b1, 5'd2, 1'b1);
    #1;
    chk_ctl("lu_rs1_ctl", 4'b0001);
    tick();
    chk("lu_rs1_cnt", {28'd0, stall_cnt}, 32'd2);
    set_lu(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);

    // taken branch: redirect + one BFLUSH
    ex_branch_taken = 1'b1;
    #1;
    chk_ctl("br_redir_ctl", 4'b1111);
    tick();
    ex_branch_taken = 1'b0;
    chk("br_bfl_state", {30'd0, state}, 32'd2);
    chk("br_flush1", {28'd0, flush_cnt}, 32'd1);
    #1;
    chk_ctl("br_bfl_ctl", 4'b1111);
    tick();
    chk("br_back_run", {30'd0, state}, 32'd1);
    chk("br_flush2", {28'd0, flush_cnt}, 32'd2);
    chk_ctl("br_run_ctl", 4'b1100);

    // branch and load-use together
    set_lu(1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    ex_branch_taken = 1'b1;
    #1;
    chk_ctl("brlu_ctl", 4'b1111);
    tick();
    chk("brlu_stall", {28'd0, stall_cnt}, 32'd2);
    chk("brlu_flush", {28'd0, flush_cnt}, 32'd3);
    // BFLUSH ignores branch and lu
    chk_ctl("bfl_ign_ctl", 4'b1111);
    tick();
    chk("bfl_ign_state", {30'd0, state}, 32'd1);
    chk("bfl_ign_stall", {28'd0, stall_cnt}, 32'd2);
    chk("bfl_ign_flush", {28'd0, flush_cnt}, 32'd4);
    ex_branch_taken = 1'b0;

    // 20 stalls saturate a 4-bit counter
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", {28'd0, stall_cnt}, 32'd15);
    chk_ctl("sat_ctl", 4'b0001);

    // clear beats a simultaneous stall
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_stall", {28'd0, stall_cnt}, 32'd0);
    chk("clr_flush", {28'd0, flush_cnt}, 32'd0);
    set_lu(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);

    // reset during BFLUSH
    ex_branch_taken = 1'b1;
    tick();
    ex_branch_taken = 1'b0;
    chk("pre_rst_state", {30'd0, state}, 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", {30'd0, state}, 32'd0);
    chk_ctl("mid_rst_ctl", 4'b0011);
    chk("mid_rst_flush", {28'd0, flush_cnt}, 32'd0);
    #3;
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_ctl($sformatf("reinit_ctl%0d", i), 4'b0011);
    end
    tick();
    chk("reinit_run", {30'd0, state}, 32'd1);
    chk_ctl("reinit_run_ctl", 4'b1100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
